// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types for the APB master arbiter.
// Holds the FSM state encoding and requester-count limit.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_arb_state_e;

  localparam int NB_REQ_MAX = 8;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester bundle plus APB bus.
// master = arbiter view, slave = requesters/APB target view.
interface apb_master_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int NB_REQ = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input logic clk
);

  logic [NB_REQ-1:0]         req;
  logic [NB_REQ-1:0][AW-1:0] addr;
  logic [NB_REQ-1:0]         we;
  logic [NB_REQ-1:0][DW-1:0] wdata;
  logic [NB_REQ-1:0]         gnt;
  logic [NB_REQ-1:0]         done;
  logic [DW-1:0]             rdata;
  logic                      err;
  logic [AW-1:0]             paddr;
  logic                      pwrite;
  logic [DW-1:0]             pwdata;
  logic                      psel;
  logic                      penable;
  logic [DW-1:0]             prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    input  clk, req, addr, we, wdata,
    input  prdata, pready, pslverr,
    output gnt, done, rdata, err,
    output paddr, pwrite, pwdata, psel, penable
  );

  modport slave (
    input  clk, gnt, done, rdata, err,
    input  paddr, pwrite, pwdata, psel, penable,
    output req, addr, we, wdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at/after ptr.
// Ports: req, ptr in; gnt (one-hot), idx, valid out.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && req[j[PW-1:0]]) begin
        valid            = 1'b1;
        gnt[j[PW-1:0]]   = 1'b1;
        idx              = j[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin share of one APB port, with watchdog.
// Ports: requester req/addr/we/wdata -> gnt/done/rdata/err; flat APB master.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NB_REQ         = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NB_REQ-1:0]                      req_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]  addr_i,
  input  logic [NB_REQ-1:0]                      we_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]  wdata_i,
  output logic [NB_REQ-1:0]                      gnt_o,
  output logic [NB_REQ-1:0]                      done_o,
  output logic [APB_DATA_WIDTH-1:0]              rdata_o,
  output logic                                   err_o,
  output logic [APB_ADDR_WIDTH-1:0]              paddr_o,
  output logic                                   pwrite_o,
  output logic [APB_DATA_WIDTH-1:0]              pwdata_o,
  output logic                                   psel_o,
  output logic                                   penable_o,
  input  logic [APB_DATA_WIDTH-1:0]              prdata_i,
  input  logic                                   pready_i,
  input  logic                                   pslverr_i
);

  localparam int PW = $clog2(NB_REQ);
  localparam int WW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WD_MAX = '1;
  localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT_CYCLES);
  localparam bit            WD_ON  = (TIMEOUT_CYCLES != 0);

  apb_arb_state_e state_q, state_d;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [WW-1:0] wd_q, wd_d, wd_inc;
  logic          timeout;

  logic [NB_REQ-1:0]          elig;
  logic [NB_REQ-1:0]          arb_gnt;
  logic [PW-1:0]              arb_idx;
  logic                       arb_valid;

  logic [APB_ADDR_WIDTH-1:0]  paddr_d;
  logic                       pwrite_d;
  logic [APB_DATA_WIDTH-1:0]  pwdata_d;
  logic                       psel_d;
  logic                       penable_d;
  logic [NB_REQ-1:0]          gnt_d;
  logic [NB_REQ-1:0]          done_d;
  logic [APB_DATA_WIDTH-1:0]  rdata_d;
  logic                       err_d;

  // The requester just served is masked for the done cycle,
  // since its req_i may still be high when done_o is seen.
  assign elig = req_i & ~done_o;

  rr_arbiter #(
    .N  (NB_REQ),
    .PW (PW)
  ) u_rr (
    .req   (elig),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign wd_inc  = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
  // pready_i wins over an expiring watchdog in the same cycle.
  assign timeout = WD_ON && !pready_i && (wd_inc == WD_LIM);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    wd_d      = wd_q;
    paddr_d   = paddr_o;
    pwrite_d  = pwrite_o;
    pwdata_d  = pwdata_o;
    psel_d    = psel_o;
    penable_d = penable_o;
    gnt_d     = '0;
    done_d    = '0;
    rdata_d   = rdata_o;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          win_d    = arb_idx;
          paddr_d  = addr_i[arb_idx];
          pwrite_d = we_i[arb_idx];
          pwdata_d = wdata_i[arb_idx];
          psel_d   = 1'b1;
          gnt_d    = arb_gnt;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        wd_d      = '0;
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready_i || timeout) begin
          done_d[win_q] = 1'b1;
          if (pready_i) begin
            rdata_d = pwrite_o ? '0 : prdata_i;
            err_d   = pslverr_i;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ptr_d     = (win_q == PW'(NB_REQ - 1)) ?
                      '0 : win_q + 1'b1;
          state_d   = IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      wd_q      <= '0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      gnt_o     <= '0;
      done_o    <= '0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      wd_q      <= wd_d;
      paddr_o   <= paddr_d;
      pwrite_o  <= pwrite_d;
      pwdata_o  <= pwdata_d;
      psel_o    <= psel_d;
      penable_o <= penable_d;
      gnt_o     <= gnt_d;
      done_o    <= done_d;
      rdata_o   <= rdata_d;
      err_o     <= err_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed self-checking bench.
// Drives requesters and a scripted APB slave through the interface.
module tb_apb_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  apb_master_arbiter_if #(
    .NB_REQ (N),
    .AW     (AW),
    .DW     (DW)
  ) bus (
    .clk (clk)
  );

  apb_master_arbiter #(
    .NB_REQ         (N),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (bus.req),
    .addr_i    (bus.addr),
    .we_i      (bus.we),
    .wdata_i   (bus.wdata),
    .gnt_o     (bus.gnt),
    .done_o    (bus.done),
    .rdata_o   (bus.rdata),
    .err_o     (bus.err),
    .paddr_o   (bus.paddr),
    .pwrite_o  (bus.pwrite),
    .pwdata_o  (bus.pwdata),
    .psel_o    (bus.psel),
    .penable_o (bus.penable),
    .prdata_i  (bus.prdata),
    .pready_i  (bus.pready),
    .pslverr_i (bus.pslverr)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [N-1:0] g;
  logic [N-1:0] d;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output logic [N-1:0] gv);
    gv = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        gv = bus.gnt;
        break;
      end
    end
  endtask

  task automatic wait_done(output logic [N-1:0] dv);
    dv = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        dv = bus.done;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bus.req     = '0;
    bus.addr    = '0;
    bus.we      = '0;
    bus.wdata   = '0;
    bus.prdata  = '0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 64'({bus.psel, bus.penable, bus.gnt,
                         bus.done, bus.err}), 64'(0));
    chk("rst_rdata", 64'(bus.rdata), 64'(0));
    chk("rst_paddr", 64'(bus.paddr), 64'(0));
    rst_n = 1'b1;

    // round-robin: both requesting, 4 transfers
    bus.pready   = 1'b1;
    bus.req      = 2'b11;
    bus.we       = 2'b11;
    bus.addr[0]  = 32'h0000_0100;
    bus.addr[1]  = 32'h0000_0200;
    bus.wdata[0] = 32'h1111_1111;
    bus.wdata[1] = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g);
      chk("rr_gnt", 64'(g), (i % 2) ? 64'h2 : 64'h1);
      if (i == 3) begin
        chk("rr_paddr", 64'(bus.paddr), 64'h200);
        bus.req = '0;
      end
    end
    wait_done(d);
    chk("rr_last_done", 64'(d), 64'h2);

    // single write, zero wait (pointer back at 0)
    bus.req      = 2'b01;
    bus.we       = 2'b01;
    bus.addr[0]  = 32'h1A10_7000;
    bus.wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_setup", 64'({bus.gnt, bus.psel, bus.penable,
                         bus.pwrite}), 64'b01_1_0_1);
    chk("wr_paddr", 64'(bus.paddr), 64'h1A10_7000);
    chk("wr_pwdata", 64'(bus.pwdata), 64'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_access", 64'({bus.psel, bus.penable, bus.done}),
        64'b1_1_00);
    @(negedge clk);
    chk("wr_done", 64'({bus.done, bus.err, bus.psel,
                        bus.penable}), 64'b01_0_0_0);
    chk("wr_rdata", 64'(bus.rdata), 64'h0);
    bus.req = '0;

    // read with 5 wait states (pointer at 1)
    bus.req     = 2'b10;
    bus.we      = 2'b00;
    bus.addr[1] = 32'h2000_0040;
    bus.prdata  = 32'h1234_5678;
    bus.pready  = 1'b0;
    @(negedge clk);
    chk("ws_setup", 64'({bus.gnt, bus.psel, bus.penable}),
        64'b10_1_0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ws_stable", {29'h0, bus.psel, bus.penable,
                        bus.pwrite, bus.paddr},
          {29'h0, 3'b110, 32'h2000_0040});
    end
    @(negedge clk);
    chk("ws_no_done", 64'(bus.done), 64'h0);
    bus.pready = 1'b1;
    @(negedge clk);
    chk("ws_done", 64'({bus.done, bus.err}), 64'b10_0);
    chk("ws_rdata", 64'(bus.rdata), 64'h1234_5678);
    bus.req = '0;
    @(negedge clk);
    chk("ws_pulse", 64'({bus.done, bus.gnt, bus.err}), 64'h0);
    chk("ws_hold", 64'(bus.rdata), 64'h1234_5678);

    // timeout after 8 ACCESS cycles (pointer at 0)
    bus.req     = 2'b01;
    bus.we      = 2'b00;
    bus.addr[0] = 32'h3000_0000;
    bus.prdata  = 32'hFFFF_0000;
    bus.pready  = 1'b0;
    @(negedge clk);
    chk("to_setup", 64'(bus.gnt), 64'h1);
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk("to_wait", 64'({bus.psel, bus.penable, bus.done}),
          64'b1_1_00);
    end
    @(negedge clk);
    chk("to_done", 64'({bus.done, bus.err, bus.psel,
                        bus.penable}), 64'b01_1_0_0);
    chk("to_rdata", 64'(bus.rdata), 64'h0);
    bus.req = '0;

    // next request after timeout served normally
    bus.req      = 2'b10;
    bus.we       = 2'b10;
    bus.wdata[1] = 32'h55AA_55AA;
    bus.pready   = 1'b1;
    wait_done(d);
    chk("to_next_done", 64'(d), 64'h2);
    chk("to_next_err", 64'(bus.err), 64'h0);
    bus.req = '0;

    // slave error (pointer at 0)
    bus.req     = 2'b01;
    bus.we      = 2'b00;
    bus.prdata  = 32'hCAFE_0001;
    bus.pslverr = 1'b1;
    wait_done(d);
    chk("se_done", 64'(d), 64'h1);
    chk("se_err", 64'(bus.err), 64'h1);
    chk("se_rdata", 64'(bus.rdata), 64'hCAFE_0001);
    bus.req = '0;
    @(negedge clk);
    chk("se_err_pulse", 64'(bus.err), 64'h0);
    bus.pslverr = 1'b0;

    // reset in ACCESS (pointer at 1 before reset)
    bus.req    = 2'b10;
    bus.we     = 2'b00;
    bus.pready = 1'b0;
    wait_gnt(g);
    chk("rs_gnt", 64'(g), 64'h2);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async", 64'({bus.psel, bus.penable}), 64'h0);
    bus.req = '0;
    @(negedge clk);
    chk("rs_no_done", 64'(bus.done), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_no_done2", 64'(bus.done), 64'h0);

    // pointer reset to 0; pready on the timeout cycle wins;
    // requester drops req after grant and still gets done
    bus.req     = 2'b11;
    bus.we      = 2'b00;
    bus.addr[0] = 32'h4000_0000;
    bus.prdata  = 32'h0BAD_F00D;
    bus.pready  = 1'b0;
    wait_gnt(g);
    chk("rs_ptr_gnt", 64'(g), 64'h1);
    bus.req = '0;
    for (int k = 0; k < TO - 1; k++) begin
      @(negedge clk);
      chk("race_wait", 64'({bus.psel, bus.penable, bus.done}),
          64'b1_1_00);
    end
    @(negedge clk);
    bus.pready = 1'b1;
    @(negedge clk);
    chk("race_done", 64'({bus.done, bus.err}), 64'b01_0);
    chk("race_rdata", 64'(bus.rdata), 64'h0BAD_F00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
